reg_file: RTL and testbench
===========================

// Module: reg_file
// PURPOSE
//   General-purpose register file feeding the ALU operand inputs (rega/regb).
//   Holds NREGS x DATA_W registers, with two combinational read ports and one synchronous write port.
//   Includes a write-through bypass and a status-flag register that captures the ALU zero/sign outputs.
//   Sits between instruction decode and the ALU in the single-cycle datapath.
// PARAMETERS
//   DATA_W  16  register and datapath width in bits
//   ADDR_W  3   register address width; NREGS = 2**ADDR_W (default 8)
// PORTS
//   clk        in   1       system clock; all state updates on rising edge
//   rst_n      in   1       asynchronous, active-low reset
//   rs_addr    in   ADDR_W  read address, port A
//   rt_addr    in   ADDR_W  read address, port B
//   we         in   1       register write enable
//   rd_addr    in   ADDR_W  write address
//   wdata      in   DATA_W  write data (ALU result or memory data, muxed upstream)
//   rega       out  DATA_W  port A read data -> ALU rega
//   regb       out  DATA_W  port B read data -> ALU regb
//   flag_we    in   1       capture enable for the ALU flags
//   alu_zero   in   1       ALU zero output
//   alu_sign   in   1       ALU sign output
//   zero_flag  out  1       registered zero flag
//   sign_flag  out  1       registered sign flag
// BEHAVIOUR
//   - Reset
//       * rst_n low clears every register and both flags to 0 immediately, without waiting for clk.
//       * While rst_n is low, rega/regb read 0, the bypass is disabled, and writes are ignored.
//       * Reset asserted mid-write: the write is lost and the register reads 0.
//   - Register 0
//       * Hardwired to 0. Writes to address 0 are discarded; reads of address 0 return 0, including via the bypass.
//   - Write
//       * On a rising clk edge with we=1, rst_n=1 and rd_addr!=0, regs[rd_addr] <= wdata.
//       * Storage latency is one cycle.
//   - Read
//       * Purely combinational from the address inputs; zero cycle latency.
//   - Bypass
//       * If we=1, rd_addr!=0 and rd_addr==rs_addr (or rt_addr), the port outputs wdata in the same cycle, not the stale content.
//       * Both ports may bypass simultaneously when rs_addr==rt_addr==rd_addr.
//   - Flags
//       * On a rising edge with flag_we=1: zero_flag <= alu_zero and sign_flag <= alu_sign.
//       * Otherwise both flags hold.
//       * flag_we and we are independent; both may fire in the same cycle.
//   - Widths
//       * No arithmetic is performed. wdata is stored unmodified at full DATA_W.
//       * Addresses are unsigned and always in range (2**ADDR_W entries).
// CONFIGURATION
//   REGFILE_DEBUG_PORT_EN
//     defined:
//       * Adds ports dbg_addr (in, ADDR_W) and dbg_data (out, DATA_W).
//       * dbg_data is a combinational third read port of the stored value; it is not bypassed.
//       * dbg_data reads 0 for address 0 and during reset.
//     undefined:
//       * Neither port exists; the remaining behaviour is identical.
// TESTING
//   1. Assert rst_n=0 async between edges -> rega=regb=0, zero_flag=sign_flag=0, no clk edge required.
//   2. we=1, rd=3, wdata=16'h1234, then rs=3 next cycle -> rega=16'h1234; regs[3] holds afterwards with we=0.
//   3. we=1, rd=0, wdata=16'hFFFF; rs=rt=0 -> rega=regb=0 both in the same cycle and the next.
//   4. regs[5]=16'h00AA; we=1, rd=5, wdata=16'h5555, rs=rt=5 same cycle -> rega=regb=16'h5555 before the edge.
//   5. flag_we=1, alu_zero=1, alu_sign=0, then flag_we=0, alu_zero=0 -> zero_flag=1 held.
//      Next, flag_we=1, alu_sign=1 -> sign_flag=1.
//   6. Write 16'hBEEF to r7, assert rst_n=0 on the same edge -> r7 reads 0.
//      With the macro defined: dbg_addr=7 -> dbg_data=0.

Source files
------------

// File: rtl/reg_file.sv
// reg_file: NREGS x DATA_W register file, 2 comb read ports, 1 write port.
// Optional debug read port under REGFILE_DEBUG_PORT_EN.
module reg_file #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic              we,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rega,
  output logic [DATA_W-1:0] regb,
  input  logic              flag_we,
  input  logic              alu_zero,
  input  logic              alu_sign,
`ifdef REGFILE_DEBUG_PORT_EN
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
`endif
  output logic              zero_flag,
  output logic              sign_flag
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NREGS];
  logic              wr_ok;

  assign wr_ok = we && (rd_addr != '0);

  // r0 is cleared on reset and never written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
    end else if (wr_ok) begin
      regs[rd_addr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_flag <= 1'b0;
      sign_flag <= 1'b0;
    end else if (flag_we) begin
      zero_flag <= alu_zero;
      sign_flag <= alu_sign;
    end
  end

  always_comb begin
    rega = '0;
    regb = '0;
    if (rst_n) begin
      if (rs_addr != '0)
        rega = (wr_ok && rd_addr == rs_addr)
             ? wdata : regs[rs_addr];
      if (rt_addr != '0)
        regb = (wr_ok && rd_addr == rt_addr)
             ? wdata : regs[rt_addr];
    end
  end

`ifdef REGFILE_DEBUG_PORT_EN
  assign dbg_data = (rst_n && dbg_addr != '0)
                  ? regs[dbg_addr] : '0;
`endif

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed vectors, queued expectations, monitor compares.
// Define REGFILE_DEBUG_PORT_EN to also check the debug read port.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  rs_addr, rt_addr, rd_addr, dbg_addr;
  logic        we, flag_we, alu_zero, alu_sign;
  logic [15:0] wdata, rega, regb, dbg_act;
  logic        zero_flag, sign_flag;

  typedef struct {
    string       n;
    logic [15:0] a;
    logic [15:0] b;
    logic        z;
    logic        s;
    logic [15:0] d;
  } exp_t;

  exp_t q[$];
  event ev;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  reg_file #(.DATA_W(16), .ADDR_W(3)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rs_addr(rs_addr),
    .rt_addr(rt_addr),
    .we(we),
    .rd_addr(rd_addr),
    .wdata(wdata),
    .rega(rega),
    .regb(regb),
    .flag_we(flag_we),
    .alu_zero(alu_zero),
    .alu_sign(alu_sign),
`ifdef REGFILE_DEBUG_PORT_EN
    .dbg_addr(dbg_addr),
    .dbg_data(dbg_act),
`endif
    .zero_flag(zero_flag),
    .sign_flag(sign_flag)
  );

`ifndef REGFILE_DEBUG_PORT_EN
  assign dbg_act = '0;
`endif

  task automatic chk(input string n,
                     input logic [15:0] a,
                     input logic [15:0] b,
                     input logic z,
                     input logic s,
                     input logic [15:0] d);
    exp_t e;
    #1;
    e.n = n; e.a = a; e.b = b;
    e.z = z; e.s = s; e.d = d;
    q.push_back(e);
    -> ev;
    #1;
  endtask

  always @(ev) begin
    exp_t e;
    logic ok;
    total++;
    if (q.size() == 0) begin
      bad++;
      $display("FAIL monitor: no expectation queued");
    end else begin
      e = q.pop_front();
      ok = (rega === e.a) && (regb === e.b)
        && (zero_flag === e.z) && (sign_flag === e.s);
`ifdef REGFILE_DEBUG_PORT_EN
      ok = ok && (dbg_act === e.d);
`endif
      if (!ok) begin
        bad++;
        $display("FAIL %s: got a=%h b=%h z=%b s=%b d=%h want a=%h b=%h z=%b s=%b d=%h",
                 e.n, rega, regb, zero_flag, sign_flag, dbg_act,
                 e.a, e.b, e.z, e.s, e.d);
      end
    end
  end

  initial begin
    rst_n = 1'b0; we = 1'b0; flag_we = 1'b0;
    alu_zero = 1'b0; alu_sign = 1'b0;
    rs_addr = '0; rt_addr = '0; rd_addr = '0;
    dbg_addr = '0; wdata = '0;
    #2 chk("reset", 16'h0, 16'h0, 0, 0, 16'h0);

    @(negedge clk);
    rst_n = 1'b1;
    we = 1; rd_addr = 3; wdata = 16'h1234;
    rs_addr = 3; rt_addr = 0; dbg_addr = 3;
    chk("wr_bypass", 16'h1234, 16'h0, 0, 0, 16'h0);

    @(negedge clk);
    we = 0; rt_addr = 3;
    chk("rd_r3", 16'h1234, 16'h1234, 0, 0, 16'h1234);
    @(negedge clk);
    chk("hold_r3", 16'h1234, 16'h1234, 0, 0, 16'h1234);

    we = 1; rd_addr = 0; wdata = 16'hFFFF;
    rs_addr = 0; rt_addr = 0; dbg_addr = 0;
    chk("r0_bypass", 16'h0, 16'h0, 0, 0, 16'h0);
    @(negedge clk);
    we = 0;
    chk("r0_after", 16'h0, 16'h0, 0, 0, 16'h0);

    we = 1; rd_addr = 5; wdata = 16'h00AA;
    @(negedge clk);
    wdata = 16'h5555;
    rs_addr = 5; rt_addr = 5; dbg_addr = 5;
    chk("dual_bypass", 16'h5555, 16'h5555, 0, 0, 16'h00AA);
    rt_addr = 3;
    chk("a_bypass", 16'h5555, 16'h1234, 0, 0, 16'h00AA);

    @(negedge clk);
    rd_addr = 4; wdata = 16'hA5A5;
    rs_addr = 5; rt_addr = 3;
    chk("no_bypass", 16'h5555, 16'h1234, 0, 0, 16'h5555);

    @(negedge clk);
    rd_addr = 2; wdata = 16'h0F0F;
    flag_we = 1; alu_zero = 1; alu_sign = 0;
    rs_addr = 4; rt_addr = 2; dbg_addr = 4;
    chk("flag_pre", 16'hA5A5, 16'h0F0F, 0, 0, 16'hA5A5);

    @(negedge clk);
    we = 0; flag_we = 0; alu_zero = 0; alu_sign = 1;
    chk("flag_zero", 16'hA5A5, 16'h0F0F, 1, 0, 16'hA5A5);
    @(negedge clk);
    chk("flag_hold", 16'hA5A5, 16'h0F0F, 1, 0, 16'hA5A5);

    flag_we = 1; alu_zero = 0; alu_sign = 1;
    @(negedge clk);
    flag_we = 0;
    chk("flag_sign", 16'hA5A5, 16'h0F0F, 0, 1, 16'hA5A5);

    we = 1; rd_addr = 6; wdata = 16'hFFFF;
    @(negedge clk);
    rd_addr = 1; wdata = 16'h8000;
    rs_addr = 6; rt_addr = 1; dbg_addr = 6;
    chk("full_width", 16'hFFFF, 16'h8000, 0, 1, 16'hFFFF);

    @(negedge clk);
    rd_addr = 7; wdata = 16'hBEEF;
    rs_addr = 7; rt_addr = 1; dbg_addr = 7;
    chk("r7_bypass", 16'hBEEF, 16'h8000, 0, 1, 16'h0);

    @(posedge clk);
    rst_n = 1'b0;
    chk("rst_async", 16'h0, 16'h0, 0, 0, 16'h0);

    @(negedge clk);
    rd_addr = 6; wdata = 16'h1111; rs_addr = 6;
    chk("rst_no_wr", 16'h0, 16'h0, 0, 0, 16'h0);

    @(negedge clk);
    we = 0; rst_n = 1'b1;
    rs_addr = 7; rt_addr = 6; dbg_addr = 7;
    chk("r7_lost", 16'h0, 16'h0, 0, 0, 16'h0);
    rs_addr = 3; rt_addr = 1; dbg_addr = 3;
    chk("all_clear", 16'h0, 16'h0, 0, 0, 16'h0);

    for (int i = 0; i < 10 && q.size() != 0; i++)
      @(negedge clk);
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: left=%0d want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
